// File: rtl/regstat_mp_pkg.sv
// regstat_mp_pkg: shared defaults and types for the multi-ported register
// status table (regstat_mp) and its per-register entry (regstat_mp_entry).
//
// Contents:
//   REGSTAT_*   default parameter values and the fixed register-index width
//   reg_stat_t  {busy, rob} entry layout at the default ROB tag width
//
// Modules that take ROB_W as a parameter use the same {busy, rob} layout,
// packed as a (ROB_W+1)-bit vector with busy in the MSB.
package regstat_mp_pkg;

    localparam int REGSTAT_NUM_REGS = 32;
    localparam int REGSTAT_ROB_W    = 4;
    localparam int REGSTAT_ISSUE_W  = 2;
    localparam int REGSTAT_COMMIT_W = 2;
    localparam int REGSTAT_NUM_CKPT = 4;
    localparam int REGSTAT_REG_W    = 5;

    typedef struct packed {
        logic                     busy;
        logic [REGSTAT_ROB_W-1:0] rob;
    } reg_stat_t;

endpackage

// File: rtl/regstat_mp_entry.sv
// regstat_mp_entry: one {busy, rob} status entry for architectural register
// reg_idx. It is used both for the live table and for checkpoint banks.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset (clears the entry)
//   flush        clears the entry at the next edge (tied low for banks)
//   reg_idx      register number this entry tracks (constant per instance)
//   load_en      replace the current value with load_val before updates
//   load_val     {busy, rob} value to load
//   wr_en/wr_rob issue write; overrides any commit clear this cycle
//   cmt_*        commit slots; a slot clears the entry when dest and tag match
//   q            current {busy, rob}
//
// Next-state priority: reset/flush > issue write > commit clear > hold/load.
// The commit clear is evaluated against the loaded value when load_en is set,
// so restored or freshly saved data never keeps a retired producer.
module regstat_mp_entry
    import regstat_mp_pkg::*;
#(
    parameter int ROB_W    = REGSTAT_ROB_W,
    parameter int COMMIT_W = REGSTAT_COMMIT_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [REGSTAT_REG_W-1:0]          reg_idx,
    input  logic                              load_en,
    input  logic [ROB_W:0]                    load_val,
    input  logic                              wr_en,
    input  logic [ROB_W-1:0]                  wr_rob,
    input  logic [COMMIT_W-1:0]               cmt_valid,
    input  logic [COMMIT_W*REGSTAT_REG_W-1:0] cmt_dest,
    input  logic [COMMIT_W*ROB_W-1:0]         cmt_rob,
    output logic [ROB_W:0]                    q
);

    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] rob;
    } stat_t;

    stat_t cur;
    stat_t base;
    stat_t nxt;
    logic  clr;

    assign q = cur;

    always_comb begin
        base = load_en ? stat_t'(load_val) : cur;
        clr  = 1'b0;
        // Only the commit whose tag matches the recorded producer clears;
        // stale commits to the same register are no-ops.
        for (int c = 0; c < COMMIT_W; c++) begin
            if (cmt_valid[c] && base.busy &&
                cmt_dest[c*REGSTAT_REG_W +: REGSTAT_REG_W] == reg_idx &&
                cmt_rob[c*ROB_W +: ROB_W] == base.rob) begin
                clr = 1'b1;
            end
        end
        nxt = base;
        if (wr_en) begin
            nxt.busy = 1'b1;
            nxt.rob  = wr_rob;
        end else if (clr) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

endmodule

// File: rtl/regstat_mp.sv
// regstat_mp: multi-ported register status table for the issue stage.
// Tracks, per architectural register, whether a result is pending and the
// ROB tag of its producer. Register 0 is hardwired not-busy.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (table + banks)
//   flush             mispredict: clears the table at the next edge
//   iss_rs1/rs2/dest  per-slot source/destination registers (slot 0 oldest)
//   iss_we, iss_rob   per-slot issue write enable and ROB tag
//   cmt_valid/dest/rob  per-slot commit (register-writing retire)
//   q_j, q_k          producer tag per source (combinational)
//   rs1_busy/rs2_busy source pending (combinational)
//   ckpt_save/restore/id  checkpoint control (only with REGSTAT_CKPT_EN)
//
// Build option: define REGSTAT_CKPT_EN to add NUM_CKPT snapshot banks and
// the ckpt_* ports. Without it, recovery is flush-only.
module regstat_mp
    import regstat_mp_pkg::*;
#(
    parameter int NUM_REGS = REGSTAT_NUM_REGS,
    parameter int ROB_W    = REGSTAT_ROB_W,
    parameter int ISSUE_W  = REGSTAT_ISSUE_W,
    parameter int COMMIT_W = REGSTAT_COMMIT_W,
    parameter int NUM_CKPT = REGSTAT_NUM_CKPT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [ISSUE_W*REGSTAT_REG_W-1:0]  iss_rs1,
    input  logic [ISSUE_W*REGSTAT_REG_W-1:0]  iss_rs2,
    input  logic [ISSUE_W*REGSTAT_REG_W-1:0]  iss_dest,
    input  logic [ISSUE_W-1:0]                iss_we,
    input  logic [ISSUE_W*ROB_W-1:0]          iss_rob,
    input  logic [COMMIT_W-1:0]               cmt_valid,
    input  logic [COMMIT_W*REGSTAT_REG_W-1:0] cmt_dest,
    input  logic [COMMIT_W*ROB_W-1:0]         cmt_rob,
    output logic [ISSUE_W*ROB_W-1:0]          q_j,
    output logic [ISSUE_W*ROB_W-1:0]          q_k,
    output logic [ISSUE_W-1:0]                rs1_busy,
    output logic [ISSUE_W-1:0]                rs2_busy
`ifdef REGSTAT_CKPT_EN
    ,
    input  logic                              ckpt_save,
    input  logic                              ckpt_restore,
    input  logic [$clog2(NUM_CKPT)-1:0]       ckpt_id
`endif
);

    localparam int REG_W = REGSTAT_REG_W;

    logic [ROB_W:0]   tbl_q  [NUM_REGS];
    logic             wr_en  [NUM_REGS];
    logic [ROB_W-1:0] wr_rob [NUM_REGS];

    // Issue write decode: ascending slot order lets the youngest slot win.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_en[r]  = 1'b0;
            wr_rob[r] = '0;
            for (int k = 0; k < ISSUE_W; k++) begin
                if (r != 0 && iss_we[k] &&
                    iss_dest[k*REG_W +: REG_W] == REG_W'(r)) begin
                    wr_en[r]  = 1'b1;
                    wr_rob[r] = iss_rob[k*ROB_W +: ROB_W];
                end
            end
        end
    end

`ifdef REGSTAT_CKPT_EN
    localparam int CKPT_IW = $clog2(NUM_CKPT);

    logic [ROB_W:0]      bank_q [NUM_CKPT][NUM_REGS];
    logic [NUM_CKPT-1:0] save_sel;

    // Restore beats save; a flushed cycle has nothing worth snapshotting.
    always_comb begin
        for (int b = 0; b < NUM_CKPT; b++) begin
            save_sel[b] = ckpt_save && !ckpt_restore && !flush &&
                          (ckpt_id == CKPT_IW'(b));
        end
    end

    // A saving bank rebuilds the table's post-update value from the current
    // table entry plus this cycle's issue write and commit clear.
    for (genvar b = 0; b < NUM_CKPT; b++) begin : g_bank
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_breg
            if (r == 0) begin : g_zero
                assign bank_q[b][r] = '0;
            end else begin : g_ent
                regstat_mp_entry #(
                    .ROB_W   (ROB_W),
                    .COMMIT_W(COMMIT_W)
                ) u_bank_entry (
                    .clk      (clk),
                    .reset    (reset),
                    .flush    (1'b0),
                    .reg_idx  (REG_W'(r)),
                    .load_en  (save_sel[b]),
                    .load_val (tbl_q[r]),
                    .wr_en    (save_sel[b] && wr_en[r]),
                    .wr_rob   (wr_rob[r]),
                    .cmt_valid(cmt_valid),
                    .cmt_dest (cmt_dest),
                    .cmt_rob  (cmt_rob),
                    .q        (bank_q[b][r])
                );
            end
        end
    end
`endif

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign tbl_q[r] = '0;
        end else begin : g_ent
            regstat_mp_entry #(
                .ROB_W   (ROB_W),
                .COMMIT_W(COMMIT_W)
            ) u_entry (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .reg_idx  (REG_W'(r)),
`ifdef REGSTAT_CKPT_EN
                .load_en  (ckpt_restore),
                .load_val (bank_q[ckpt_id][r]),
                .wr_en    (wr_en[r] && !ckpt_restore),
`else
                .load_en  (1'b0),
                .load_val ('0),
                .wr_en    (wr_en[r]),
`endif
                .wr_rob   (wr_rob[r]),
                .cmt_valid(cmt_valid),
                .cmt_dest (cmt_dest),
                .cmt_rob  (cmt_rob),
                .q        (tbl_q[r])
            );
        end
    end

    // Lookup: table entry, hidden if a commit retires its producer this
    // cycle (write-through regfile), overridden by the youngest older slot.
    always_comb begin
        logic [REG_W-1:0] src;
        logic [ROB_W:0]   ent;
        logic             hit;
        logic             bsy;
        logic [ROB_W-1:0] tag;
        q_j      = '0;
        q_k      = '0;
        rs1_busy = '0;
        rs2_busy = '0;
        src      = '0;
        ent      = '0;
        hit      = 1'b0;
        bsy      = 1'b0;
        tag      = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int s = 0; s < 2; s++) begin
                src = (s == 0) ? iss_rs1[i*REG_W +: REG_W] : iss_rs2[i*REG_W +: REG_W];
                ent = (int'(src) < NUM_REGS) ? tbl_q[src] : '0;
                hit = 1'b0;
                for (int c = 0; c < COMMIT_W; c++) begin
                    if (cmt_valid[c] && cmt_dest[c*REG_W +: REG_W] == src &&
                        cmt_rob[c*ROB_W +: ROB_W] == ent[ROB_W-1:0]) begin
                        hit = 1'b1;
                    end
                end
                bsy = 1'b0;
                tag = '0;
                if (src != '0) begin
                    if (ent[ROB_W] && !hit) begin
                        bsy = 1'b1;
                        tag = ent[ROB_W-1:0];
                    end
                    for (int k = 0; k < ISSUE_W; k++) begin
                        if (k < i && iss_we[k] && iss_dest[k*REG_W +: REG_W] == src) begin
                            bsy = 1'b1;
                            tag = iss_rob[k*ROB_W +: ROB_W];
                        end
                    end
                end
                if (s == 0) begin
                    rs1_busy[i]              = bsy;
                    q_j[i*ROB_W +: ROB_W]    = tag;
                end else begin
                    rs2_busy[i]              = bsy;
                    q_k[i*ROB_W +: ROB_W]    = tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_regstat_mp.sv
module tb_regstat_mp;

    localparam int NR = 32;
    localparam int RB = 4;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, flush;
    logic [IW*5-1:0]   iss_rs1, iss_rs2, iss_dest;
    logic [IW-1:0]     iss_we;
    logic [IW*RB-1:0]  iss_rob;
    logic [CW-1:0]     cmt_valid;
    logic [CW*5-1:0]   cmt_dest;
    logic [CW*RB-1:0]  cmt_rob;
    logic [IW*RB-1:0]  q_j, q_k;
    logic [IW-1:0]     rs1_busy, rs2_busy;
`ifdef REGSTAT_CKPT_EN
    logic              ckpt_save, ckpt_restore;
    logic [1:0]        ckpt_id;
`endif

    regstat_mp #(.NUM_REGS(NR), .ROB_W(RB), .ISSUE_W(IW), .COMMIT_W(CW), .NUM_CKPT(NC)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_dest(iss_dest),
        .iss_we(iss_we), .iss_rob(iss_rob),
        .cmt_valid(cmt_valid), .cmt_dest(cmt_dest), .cmt_rob(cmt_rob),
        .q_j(q_j), .q_k(q_k), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
`ifdef REGSTAT_CKPT_EN
        , .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .ckpt_id(ckpt_id)
`endif
    );

    // Stimulus for the current cycle
    int s_rs1[IW], s_rs2[IW], s_dest[IW], s_we[IW], s_rob[IW];
    int c_v[CW], c_dest[CW], c_rob[CW];
    int s_reset, s_flush, s_save, s_restore, s_id;

    // Reference model: architectural view of the table and snapshot banks
    int mb[NR], mr[NR];
    int bb[NC][NR], br[NC][NR];

    typedef struct {
        logic [IW*RB-1:0] qj, qk;
        logic [IW-1:0]    b1, b2;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    function automatic int cmt_hit(input int r, input int tag);
        for (int c = 0; c < CW; c++)
            if (c_v[c] != 0 && c_dest[c] == r && c_rob[c] == tag) return 1;
        return 0;
    endfunction

    function automatic void model_lookup(input int i, input int src, output int busy, output int tag);
        busy = 0; tag = 0;
        if (src == 0) return;
        for (int k = i - 1; k >= 0; k--) begin
            if (s_we[k] != 0 && s_dest[k] == src) begin
                busy = 1; tag = s_rob[k]; return;
            end
        end
        if (mb[src] != 0 && cmt_hit(src, mr[src]) == 0) begin
            busy = 1; tag = mr[src];
        end
    endfunction

    function automatic void model_update();
        int nb[NR];
        int nr[NR];
        if (s_reset != 0) begin
            for (int r = 0; r < NR; r++) begin
                mb[r] = 0; mr[r] = 0;
                for (int b = 0; b < NC; b++) begin bb[b][r] = 0; br[b][r] = 0; end
            end
            return;
        end
        for (int b = 0; b < NC; b++)
            for (int r = 0; r < NR; r++)
                if (bb[b][r] != 0 && cmt_hit(r, br[b][r]) != 0) begin bb[b][r] = 0; br[b][r] = 0; end
        if (s_flush != 0) begin
            for (int r = 0; r < NR; r++) begin mb[r] = 0; mr[r] = 0; end
            return;
        end
        for (int r = 0; r < NR; r++) begin
            if (s_restore != 0) begin
                nb[r] = bb[s_id][r]; nr[r] = br[s_id][r];
            end else begin
                nb[r] = mb[r]; nr[r] = mr[r];
                if (nb[r] != 0 && cmt_hit(r, nr[r]) != 0) begin nb[r] = 0; nr[r] = 0; end
            end
        end
        if (s_restore == 0)
            for (int k = 0; k < IW; k++)
                if (s_we[k] != 0 && s_dest[k] != 0) begin nb[s_dest[k]] = 1; nr[s_dest[k]] = s_rob[k]; end
        for (int r = 0; r < NR; r++) begin
            mb[r] = nb[r]; mr[r] = nr[r];
            if (s_save != 0 && s_restore == 0) begin bb[s_id][r] = nb[r]; br[s_id][r] = nr[r]; end
        end
    endfunction

    task automatic idle();
        for (int i = 0; i < IW; i++) begin
            s_rs1[i] = 0; s_rs2[i] = 0; s_dest[i] = 0; s_we[i] = 0; s_rob[i] = 0;
        end
        for (int c = 0; c < CW; c++) begin c_v[c] = 0; c_dest[c] = 0; c_rob[c] = 0; end
        s_reset = 0; s_flush = 0; s_save = 0; s_restore = 0; s_id = 0;
    endtask

    // Issue one cycle: push expected lookups, drive pins, advance the model at the edge.
    task automatic do_cycle();
        exp_t e;
        int bz, tg;
        for (int i = 0; i < IW; i++) begin
            model_lookup(i, s_rs1[i], bz, tg);
            e.b1[i] = bz[0]; e.qj[i*RB +: RB] = tg[RB-1:0];
            model_lookup(i, s_rs2[i], bz, tg);
            e.b2[i] = bz[0]; e.qk[i*RB +: RB] = tg[RB-1:0];
        end
        sb.push_back(e);
        reset = s_reset[0]; flush = s_flush[0];
        for (int i = 0; i < IW; i++) begin
            iss_rs1[i*5 +: 5]   = 5'(s_rs1[i]);
            iss_rs2[i*5 +: 5]   = 5'(s_rs2[i]);
            iss_dest[i*5 +: 5]  = 5'(s_dest[i]);
            iss_we[i]           = s_we[i][0];
            iss_rob[i*RB +: RB] = RB'(s_rob[i]);
        end
        for (int c = 0; c < CW; c++) begin
            cmt_valid[c]        = c_v[c][0];
            cmt_dest[c*5 +: 5]  = 5'(c_dest[c]);
            cmt_rob[c*RB +: RB] = RB'(c_rob[c]);
        end
`ifdef REGSTAT_CKPT_EN
        ckpt_save = s_save[0]; ckpt_restore = s_restore[0]; ckpt_id = 2'(s_id);
`endif
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic rand_cycle();
        idle();
        for (int i = 0; i < IW; i++) begin
            s_rs1[i]  = $urandom_range(0, 9);
            s_rs2[i]  = $urandom_range(0, 9);
            s_dest[i] = $urandom_range(0, 9);
            s_we[i]   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s_rob[i]  = $urandom_range(0, 15);
        end
        for (int c = 0; c < CW; c++) begin
            c_v[c]    = ($urandom_range(0, 2) != 0) ? 1 : 0;
            c_dest[c] = $urandom_range(0, 9);
            c_rob[c]  = ($urandom_range(0, 3) != 0) ? mr[c_dest[c]] : $urandom_range(0, 15);
        end
        s_flush = ($urandom_range(0, 29) == 0) ? 1 : 0;
        s_reset = ($urandom_range(0, 149) == 0) ? 1 : 0;
`ifdef REGSTAT_CKPT_EN
        s_save    = ($urandom_range(0, 5) == 0) ? 1 : 0;
        s_restore = ($urandom_range(0, 7) == 0) ? 1 : 0;
        s_id      = $urandom_range(0, NC - 1);
`endif
    endtask

    // Monitor: lookups are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks += 4;
            if (rs1_busy !== e.b1) begin n_errors++; $display("FAIL rs1_busy cyc=%0d got=%b exp=%b", cyc, rs1_busy, e.b1); end
            if (rs2_busy !== e.b2) begin n_errors++; $display("FAIL rs2_busy cyc=%0d got=%b exp=%b", cyc, rs2_busy, e.b2); end
            if (q_j !== e.qj) begin n_errors++; $display("FAIL q_j cyc=%0d got=%h exp=%h", cyc, q_j, e.qj); end
            if (q_k !== e.qk) begin n_errors++; $display("FAIL q_k cyc=%0d got=%h exp=%h", cyc, q_k, e.qk); end
        end
    end

    initial begin
        idle();
        for (int r = 0; r < NR; r++) begin
            mb[r] = 0; mr[r] = 0;
            for (int b = 0; b < NC; b++) begin bb[b][r] = 0; br[b][r] = 0; end
        end
        reset = 1'b1; flush = 1'b0;
        iss_rs1 = '0; iss_rs2 = '0; iss_dest = '0; iss_we = '0; iss_rob = '0;
        cmt_valid = '0; cmt_dest = '0; cmt_rob = '0;
`ifdef REGSTAT_CKPT_EN
        ckpt_save = 1'b0; ckpt_restore = 1'b0; ckpt_id = '0;
`endif
        @(posedge clk); #1;

        // Reset, then read back a spread of registers
        idle(); s_reset = 1; do_cycle(); do_cycle();
        for (int j = 0; j < 8; j++) begin
            idle(); s_rs1[0] = 4*j; s_rs2[0] = 4*j+1; s_rs1[1] = 4*j+2; s_rs2[1] = 4*j+3; do_cycle();
        end

        // Issue r5 rob3, read it, commit while reading, read again
        idle(); s_we[0] = 1; s_dest[0] = 5; s_rob[0] = 3; do_cycle();
        idle(); s_rs1[0] = 5; do_cycle();
        idle(); s_rs1[0] = 5; c_v[0] = 1; c_dest[0] = 5; c_rob[0] = 3; do_cycle();
        idle(); s_rs1[0] = 5; s_rs2[1] = 5; do_cycle();

        // Intra-group bypass and youngest-writer-wins
        idle(); s_we[0] = 1; s_dest[0] = 7; s_rob[0] = 1; s_rs1[1] = 7; do_cycle();
        idle(); s_we[0] = 1; s_dest[0] = 7; s_rob[0] = 1; s_we[1] = 1; s_dest[1] = 7; s_rob[1] = 2; do_cycle();
        idle(); s_rs1[0] = 7; s_rs2[1] = 7; do_cycle();

        // Stale commit is a no-op; issue write overrides a matching commit
        idle(); s_we[0] = 1; s_dest[0] = 9; s_rob[0] = 4; do_cycle();
        idle(); c_v[1] = 1; c_dest[1] = 9; c_rob[1] = 2; s_rs1[0] = 9; do_cycle();
        idle(); c_v[0] = 1; c_dest[0] = 9; c_rob[0] = 2; c_v[1] = 1; c_dest[1] = 9; c_rob[1] = 4;
        s_we[0] = 1; s_dest[0] = 9; s_rob[0] = 6; s_rs1[1] = 9; s_rs2[0] = 9; do_cycle();
        idle(); s_rs1[0] = 9; do_cycle();

        // Fill 1..31, then flush together with an issue
        for (int j = 0; j < 16; j++) begin
            idle();
            s_we[0] = 1; s_dest[0] = 2*j+1; s_rob[0] = j;
            if (2*j+2 < NR) begin s_we[1] = 1; s_dest[1] = 2*j+2; s_rob[1] = 15 - j; end
            s_rs1[0] = 2*j; s_rs2[1] = 2*j+1;
            do_cycle();
        end
        idle(); s_flush = 1; s_we[0] = 1; s_dest[0] = 3; s_rob[0] = 9; s_rs1[0] = 3; do_cycle();
        for (int j = 0; j < 8; j++) begin
            idle(); s_rs1[0] = 4*j; s_rs2[0] = 4*j+1; s_rs1[1] = 4*j+2; s_rs2[1] = 4*j+3; do_cycle();
        end
        idle(); s_we[0] = 1; s_dest[0] = 0; s_rob[0] = 5; s_rs1[1] = 0; do_cycle();
        idle(); s_rs1[0] = 0; s_rs2[0] = 0; do_cycle();

`ifdef REGSTAT_CKPT_EN
        // Save, overwrite, clear the saved producer in the bank, restore
        idle(); s_we[0] = 1; s_dest[0] = 3; s_rob[0] = 2; do_cycle();
        idle(); s_save = 1; s_id = 1; do_cycle();
        idle(); s_we[0] = 1; s_dest[0] = 3; s_rob[0] = 5; do_cycle();
        idle(); c_v[0] = 1; c_dest[0] = 3; c_rob[0] = 2; do_cycle();
        idle(); s_restore = 1; s_id = 1; s_we[1] = 1; s_dest[1] = 4; s_rob[1] = 7; do_cycle();
        idle(); s_rs1[0] = 3; s_rs2[0] = 4; do_cycle();
        // Save and restore together: restore applied, bank untouched
        idle(); s_we[0] = 1; s_dest[0] = 6; s_rob[0] = 8; s_save = 1; s_id = 2; do_cycle();
        idle(); s_we[0] = 1; s_dest[0] = 6; s_rob[0] = 9; do_cycle();
        idle(); s_save = 1; s_restore = 1; s_id = 2; s_rs1[0] = 6; do_cycle();
        idle(); s_we[0] = 1; s_dest[0] = 6; s_rob[0] = 11; do_cycle();
        idle(); s_restore = 1; s_id = 2; do_cycle();
        idle(); s_rs1[0] = 6; do_cycle();
        // Reset clears banks
        idle(); s_reset = 1; do_cycle();
        idle(); s_restore = 1; s_id = 2; do_cycle();
        idle(); s_rs1[0] = 6; s_rs1[1] = 3; do_cycle();
`endif

        for (int n = 0; n < 600; n++) begin
            rand_cycle();
            do_cycle();
        end

        idle(); do_cycle();
        @(negedge clk); #1;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
